// File: rtl/reg_bank_bus_ctrl.sv
// Register bank with a sequenced bus controller (READ, DR_OUT, WRITE, INC, CLR).
// Define SAT_INC_EN to make INC saturate at all-ones instead of wrapping.
module reg_bank_bus_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [2:0]                   op_code,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic [DATA_W-1:0]            dr_in,
    input  logic [DATA_W-1:0]            bus_in,
    output logic [DATA_W-1:0]            bus,
    output logic                         bus_valid,
    output logic [NUM_REGS-1:0]          en_y,
    output logic                         done,
    output logic                         err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

    typedef enum logic [1:0] {StIdle, StExec, StIncWb} state_e;

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpRead  = 3'd1;
    localparam logic [2:0] OpDrOut = 3'd2;
    localparam logic [2:0] OpWrite = 3'd3;
    localparam logic [2:0] OpInc   = 3'd4;
    localparam logic [2:0] OpClr   = 3'd5;

    localparam logic [ADDR_W:0] NumRegsW = NUM_REGS[ADDR_W:0];

    state_e              state_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   tmp_q;
    logic                bad_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W-1:0]   sel_addr;
    logic [NUM_REGS-1:0] sel_oh;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   inc_data;
    logic                cmd_bad;

    assign op_ready = (state_q == StIdle);

    // In IDLE the incoming address is decoded; afterwards the latched one.
    always_comb begin
        sel_addr = (state_q == StIdle) ? reg_addr : addr_q;
        sel_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_addr == ADDR_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_data  = regs_q[i];
            end
        end
`ifdef SAT_INC_EN
        inc_data = (&sel_data) ? sel_data : sel_data + DATA_W'(1);
`else
        inc_data = sel_data + DATA_W'(1);
`endif
        cmd_bad = ({1'b0, reg_addr} >= NumRegsW) || (op_code[2] && op_code[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OpNop;
            addr_q    <= '0;
            data_q    <= '0;
            tmp_q     <= '0;
            bad_q     <= 1'b0;
            bus       <= '0;
            bus_valid <= 1'b0;
            en_y      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            bus_valid <= 1'b0;
            en_y      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (op_valid && op_code != OpNop) begin
                        op_q    <= op_code;
                        addr_q  <= reg_addr;
                        data_q  <= (op_code == OpClr) ? '0 : bus_in;
                        bad_q   <= cmd_bad;
                        state_q <= StExec;
                        // Outputs for the EXEC cycle are registered here at accept.
                        if (cmd_bad) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            case (op_code)
                                OpRead: begin
                                    bus       <= sel_data;
                                    bus_valid <= 1'b1;
                                    done      <= 1'b1;
                                end
                                OpDrOut: begin
                                    bus       <= dr_in;
                                    bus_valid <= 1'b1;
                                    done      <= 1'b1;
                                end
                                OpWrite, OpClr: begin
                                    en_y <= sel_oh;
                                    done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StExec: begin
                    state_q <= StIdle;
                    if (!bad_q) begin
                        case (op_q)
                            OpWrite, OpClr: begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (sel_oh[i]) regs_q[i] <= data_q;
                                end
                            end
                            OpInc: begin
                                tmp_q   <= inc_data;
                                en_y    <= sel_oh;
                                done    <= 1'b1;
                                state_q <= StIncWb;
                            end
                            default: ;
                        endcase
                    end
                end
                StIncWb: begin
                    state_q <= StIdle;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (sel_oh[i]) regs_q[i] <= tmp_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_reg_bank_bus_ctrl.sv
// Directed bench for reg_bank_bus_ctrl with a reference register model and result scoreboard.
module tb_reg_bank_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = '0;
    logic [3:0]  reg_addr = '0;
    logic [7:0]  dr_in = '0;
    logic [7:0]  bus_in = '0;
    logic [7:0]  bus;
    logic        bus_valid;
    logic [7:0]  en_y;
    logic        done;
    logic        err;
    logic [63:0] regs_flat;

    reg_bank_bus_ctrl #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .reg_addr  (reg_addr),
        .dr_in     (dr_in),
        .bus_in    (bus_in),
        .bus       (bus),
        .bus_valid (bus_valid),
        .en_y      (en_y),
        .done      (done),
        .err       (err),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bus;
        logic       bv;
        logic [7:0] en_y;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] regs_m [8];
    logic [7:0] bus_m = '0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = regs_m[i];
        return f;
    endfunction

    // Issue one command at a negedge, wait for done, compare against the scoreboard.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] addr,
                           input logic [7:0] wd, input logic [7:0] dr);
        exp_t e;
        bit   seen;
        e.err  = (addr >= 4'd8) || (op >= 3'd6);
        e.bus  = bus_m;
        e.bv   = 1'b0;
        e.en_y = '0;
        e.lat  = 1;
        if (!e.err) begin
            case (op)
                3'd1: begin e.bus = regs_m[addr[2:0]]; e.bv = 1'b1; end
                3'd2: begin e.bus = dr; e.bv = 1'b1; end
                3'd3: begin e.en_y = 8'(1) << addr[2:0]; regs_m[addr[2:0]] = wd; end
                3'd5: begin e.en_y = 8'(1) << addr[2:0]; regs_m[addr[2:0]] = 8'h00; end
                3'd4: begin
                    e.en_y = 8'(1) << addr[2:0];
                    e.lat  = 2;
`ifdef SAT_INC_EN
                    if (regs_m[addr[2:0]] != 8'hFF) regs_m[addr[2:0]] = regs_m[addr[2:0]] + 8'd1;
`else
                    regs_m[addr[2:0]] = regs_m[addr[2:0]] + 8'd1;
`endif
                end
                default: ;
            endcase
        end
        bus_m = e.bus;
        sb.push_back(e);

        op_valid = 1'b1;
        op_code  = op;
        reg_addr = addr;
        bus_in   = wd;
        dr_in    = dr;
        check({tag, "_ready_in"}, 64'(op_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        bus_in   = ~wd;
        dr_in    = ~dr;
        seen     = 1'b0;
        for (int cyc = 1; cyc <= 4 && !seen; cyc++) begin
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check({tag, "_lat"}, 64'(cyc), 64'(e.lat));
                check({tag, "_bus"}, 64'(bus), 64'(e.bus));
                check({tag, "_bv"}, 64'(bus_valid), 64'(e.bv));
                check({tag, "_en_y"}, 64'(en_y), 64'(e.en_y));
                check({tag, "_err"}, 64'(err), 64'(e.err));
                check({tag, "_busy"}, 64'(op_ready), 64'd0);
            end else begin
                check({tag, "_quiet"}, {62'd0, bus_valid, |en_y}, 64'd0);
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        check({tag, "_ready_out"}, 64'(op_ready), 64'd1);
        check({tag, "_done_clr"}, {62'd0, done, |en_y}, 64'd0);
        check({tag, "_regs"}, regs_flat, model_flat());
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs_m[i] = '0;

        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_regs", regs_flat, 64'd0);
        check("rst_bus", 64'(bus), 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_pulses", {60'd0, bus_valid, |en_y, done, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd("wr_r3", 3'd3, 4'd3, 8'hA5, 8'h00);
        run_cmd("rd_r3", 3'd1, 4'd3, 8'h00, 8'h00);
        run_cmd("drout", 3'd2, 4'd0, 8'h00, 8'h3C);
        run_cmd("wr_r7", 3'd3, 4'd7, 8'hFF, 8'h00);
        run_cmd("inc_r7", 3'd4, 4'd7, 8'h00, 8'h00);
        run_cmd("rd_r7", 3'd1, 4'd7, 8'h00, 8'h00);
        run_cmd("wr_r0", 3'd3, 4'd0, 8'h7F, 8'h00);
        run_cmd("inc_r0", 3'd4, 4'd0, 8'h00, 8'h00);
        run_cmd("rd_r0", 3'd1, 4'd0, 8'h00, 8'h00);
        run_cmd("clr_r3", 3'd5, 4'd3, 8'h00, 8'h00);
        run_cmd("rd_r3b", 3'd1, 4'd3, 8'h00, 8'h00);
        run_cmd("rd_bad9", 3'd1, 4'd9, 8'h00, 8'h00);
        run_cmd("op6", 3'd6, 4'd1, 8'h00, 8'h00);
        run_cmd("inc_bad15", 3'd4, 4'd15, 8'h00, 8'h00);
        run_cmd("wr_bad8", 3'd3, 4'd8, 8'h55, 8'h00);

        // NOP is accepted but produces nothing
        op_valid = 1'b1;
        op_code  = 3'd0;
        reg_addr = 4'd2;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        check("nop_ready", 64'(op_ready), 64'd1);
        check("nop_done", 64'(done), 64'd0);

        // Reset during INC EXEC aborts the write-back
        run_cmd("wr_r5", 3'd3, 4'd5, 8'h40, 8'h00);
        op_valid = 1'b1;
        op_code  = 3'd4;
        reg_addr = 4'd5;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        check("abort_busy", 64'(op_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_en_y", 64'(en_y), 64'd0);
        check("abort_ready", 64'(op_ready), 64'd1);
        @(negedge clk);
        check("abort_en_y2", 64'(en_y), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_regs", regs_flat, 64'd0);
        check("abort_ready2", 64'(op_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
